// File: rtl/accel_ctrl_pkg.sv
// Shared types and defaults for the accelerator job controller.
package accel_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } ctrl_state_e;

  localparam int unsigned TimeoutCyclesDef = 1000;
  localparam int unsigned LatWDef          = 16;
  localparam int unsigned JobCntW          = 16;
  localparam int unsigned TimeoutCntW      = 16;
  localparam int unsigned StrayCntW        = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear; optionally holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat_en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;
  logic             at_max;

  assign at_max = &count_q;
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && !(sat_en && at_max)) begin
      count_q <= count_q + Width'(1);
    end
  end

endmodule

// File: rtl/accel_job_controller.sv
// Issues acc_start per accepted job, times the acc_finish response and keeps
// job / timeout / stray-finish statistics.
module accel_job_controller
  import accel_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef,
  parameter int unsigned LAT_W          = LatWDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  output logic                   acc_start,
  input  logic                   acc_finish,
  output logic                   done_valid,
  output logic [LAT_W-1:0]       done_latency,
  output logic                   done_timeout,
  output logic                   busy,
  output logic [JobCntW-1:0]     job_count,
  output logic [TimeoutCntW-1:0] timeout_count,
  output logic [StrayCntW-1:0]   stray_count
);

  localparam logic [LAT_W-1:0] TimeoutVal = LAT_W'(TIMEOUT_CYCLES);

  ctrl_state_e        state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]   done_latency_q, done_latency_d;
  logic               done_timeout_q, done_timeout_d;
  logic [JobCntW-1:0] job_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      lat_cnt_q      <= '0;
      done_latency_q <= '0;
      done_timeout_q <= 1'b0;
      job_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      done_latency_q <= done_latency_d;
      done_timeout_q <= done_timeout_d;
      if (state_q == StDone) begin
        job_count_q <= job_count_q + JobCntW'(1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    done_latency_d = done_latency_q;
    done_timeout_d = done_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (job_valid) state_d = StStart;
      end
      StStart: begin
        lat_cnt_d = LAT_W'(1);
        state_d   = StWait;
      end
      StWait: begin
        // A finish arriving on the timeout cycle still counts as a normal completion.
        if (acc_finish) begin
          state_d        = StDone;
          done_latency_d = lat_cnt_q;
          done_timeout_d = 1'b0;
        end else if (lat_cnt_q == TimeoutVal) begin
          state_d        = StDone;
          done_latency_d = TimeoutVal;
          done_timeout_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign job_ready    = (state_q == StIdle) && !reset;
  assign acc_start    = (state_q == StStart);
  assign done_valid   = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign done_latency = done_latency_q;
  assign done_timeout = done_timeout_q;
  assign job_count    = job_count_q;

  sat_counter #(
    .Width (TimeoutCntW)
  ) u_timeout_cnt (
    .clk    (clk),
    .clr    (reset),
    .inc    ((state_q == StDone) && done_timeout_q),
    .sat_en (1'b1),
    .count  (timeout_count)
  );

  // Any finish outside WAIT, including a late one after timeout, is stray.
  sat_counter #(
    .Width (StrayCntW)
  ) u_stray_cnt (
    .clk    (clk),
    .clr    (reset),
    .inc    (acc_finish && (state_q != StWait)),
    .sat_en (1'b1),
    .count  (stray_count)
  );

endmodule

// File: tb/tb_accel_job_controller.sv
// Directed bench for accel_job_controller: vector table of job responses plus
// hand sequences for reset, back-to-back and saturation.
module tb_accel_job_controller;

  localparam int unsigned To = 20;

  logic        clk = 1'b0;
  logic        reset, job_valid, acc_finish;
  logic        job_ready, acc_start, done_valid, done_timeout, busy;
  logic [15:0] done_latency, job_count, timeout_count;
  logic [7:0]  stray_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  accel_job_controller #(
    .TIMEOUT_CYCLES (To),
    .LAT_W          (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .acc_start     (acc_start),
    .acc_finish    (acc_finish),
    .done_valid    (done_valid),
    .done_latency  (done_latency),
    .done_timeout  (done_timeout),
    .busy          (busy),
    .job_count     (job_count),
    .timeout_count (timeout_count),
    .stray_count   (stray_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // k: finish offset after acc_start (0 = same cycle as start, -1 = never)
  typedef struct {
    int k;
    int exp_lat;
    bit exp_to;
    int exp_stray;
    int exp_done;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] jc0, tc0, exp_jc, exp_tc;
    logic [7:0]  sc0, exp_sc;
    logic [15:0] lat;
    logic        to;
    int          done_at, ready_at, extra;
    jc0 = job_count; tc0 = timeout_count; sc0 = stray_count;
    lat = '0; to = 1'b0; done_at = -1; ready_at = -1; extra = 0;
    check({tag, "_ready"}, 32'(job_ready), 32'd1);
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    check({tag, "_start"}, 32'(acc_start), 32'd1);
    for (int d = 1; d < 45; d++) begin
      if (d > 1) begin
        if (acc_start) extra++;
        if (done_valid && done_at < 0) begin
          done_at = d; lat = done_latency; to = done_timeout;
        end
        if (job_ready && ready_at < 0) ready_at = d;
      end
      acc_finish = (v.k >= 0) && (d == v.k + 1);
      step();
    end
    acc_finish = 1'b0;
    exp_jc = jc0 + 16'd1;
    exp_tc = tc0 + 16'(v.exp_to);
    exp_sc = sc0 + 8'(v.exp_stray);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(v.exp_done));
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_timeout"}, 32'(to), 32'(v.exp_to));
    check({tag, "_ready_again"}, 32'(ready_at), 32'(v.exp_done + 1));
    check({tag, "_single_start"}, 32'(extra), 32'd0);
    check({tag, "_latency_held"}, 32'(done_latency), 32'(v.exp_lat));
    check({tag, "_job_count"}, 32'(job_count), 32'(exp_jc));
    check({tag, "_timeout_count"}, 32'(timeout_count), 32'(exp_tc));
    check({tag, "_stray_count"}, 32'(stray_count), 32'(exp_sc));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_acc_start"}, 32'(acc_start), 32'd0);
    check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    check({tag, "_done_latency"}, 32'(done_latency), 32'd0);
    check({tag, "_done_timeout"}, 32'(done_timeout), 32'd0);
    check({tag, "_job_count"}, 32'(job_count), 32'd0);
    check({tag, "_timeout_count"}, 32'(timeout_count), 32'd0);
    check({tag, "_stray_count"}, 32'(stray_count), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    vec_t        basic;
    int          starts, dones, bad_spacing, dv_after_reset;
    logic        prev_start;
    logic [15:0] jc0, tc0;

    vecs[0] = '{k: 5,  exp_lat: 5,  exp_to: 0, exp_stray: 0, exp_done: 7};
    vecs[1] = '{k: 1,  exp_lat: 1,  exp_to: 0, exp_stray: 0, exp_done: 3};
    vecs[2] = '{k: 20, exp_lat: 20, exp_to: 0, exp_stray: 0, exp_done: 22};
    vecs[3] = '{k: 19, exp_lat: 19, exp_to: 0, exp_stray: 0, exp_done: 21};
    vecs[4] = '{k: -1, exp_lat: 20, exp_to: 1, exp_stray: 0, exp_done: 22};
    vecs[5] = '{k: 29, exp_lat: 20, exp_to: 1, exp_stray: 1, exp_done: 22};
    vecs[6] = '{k: 21, exp_lat: 20, exp_to: 1, exp_stray: 1, exp_done: 22};
    vecs[7] = '{k: 0,  exp_lat: 20, exp_to: 1, exp_stray: 1, exp_done: 22};
    basic   = vecs[0];

    reset = 1'b1; job_valid = 1'b0; acc_finish = 1'b0;
    step();
    step();
    check("rst_job_ready_forced_low", 32'(job_ready), 32'd0);
    check_cleared("rst");
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(job_ready), 32'd1);
    step();

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset on the third WAIT cycle discards the job.
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    step();
    step();
    step();
    check("midwait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("midwait_ready_forced_low", 32'(job_ready), 32'd0);
    check_cleared("midwait");
    reset = 1'b0;
    #1;
    check("midwait_ready_after", 32'(job_ready), 32'd1);
    dv_after_reset = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done_valid) dv_after_reset++;
    end
    check("midwait_no_done", 32'(dv_after_reset), 32'd0);
    run_vec(basic, "post_reset");

    // Back-to-back: job_valid held, stub finishes one cycle after each start.
    jc0 = job_count; tc0 = timeout_count;
    starts = 0; dones = 0; bad_spacing = 0; prev_start = 1'b0;
    for (int d = 0; d < 40; d++) begin
      if (acc_start) begin
        starts++;
        if (d % 4 != 1) bad_spacing++;
      end
      if (done_valid) dones++;
      acc_finish = prev_start;
      prev_start = acc_start;
      job_valid  = 1'b1;
      step();
    end
    job_valid = 1'b0; acc_finish = 1'b0;
    check("b2b_starts", 32'(starts), 32'd10);
    check("b2b_dones", 32'(dones), 32'd10);
    check("b2b_spacing", 32'(bad_spacing), 32'd0);
    check("b2b_job_count", 32'(job_count), 32'(jc0 + 16'd10));
    check("b2b_timeout_count", 32'(timeout_count), 32'(tc0));
    check("b2b_stray_count", 32'(stray_count), 32'd0);
    step();
    step();

    // Stray finishes in IDLE saturate at 0xFF.
    acc_finish = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("stray_100", 32'(stray_count), 32'd100);
    for (int i = 0; i < 200; i++) step();
    acc_finish = 1'b0;
    step();
    check("stray_saturated", 32'(stray_count), 32'd255);
    check("stray_idle_not_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_job_controller.md
# accel_job_controller

Controller-side counterpart of the accelerator start/finish handshake: accepts jobs from an upstream valid/ready source, issues a one-cycle `acc_start` pulse to the accelerator, waits for the one-cycle `acc_finish` pulse, and reports per-job latency or timeout. It sits between the job scheduler and any accelerator (or accelerator test stub) exposing the `acc_start`/`acc_finish` pair. It also keeps job, timeout and stray-finish statistics for host readout.

## Interface
- `TIMEOUT_CYCLES`, 1000: maximum cycles from `acc_start` to `acc_finish` before the job is declared timed out; must be ≥1 and < 2^`LAT_W`.
- `LAT_W`, 16: width of the latency result.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `job_valid`  in  1  upstream job request.
- `job_ready`  out  1  controller can accept a job; transfer on `job_valid && job_ready`.
- `acc_start`  out  1  one-cycle start pulse to accelerator.
- `acc_finish`  in  1  one-cycle completion pulse from accelerator.
- `done_valid`  out  1  one-cycle pulse: job result on `done_latency`/`done_timeout`.
- `done_latency`  out  LAT_W  cycles from `acc_start` cycle to `acc_finish` cycle; `TIMEOUT_CYCLES` on timeout.
- `done_timeout`  out  1  qualifies `done_valid`: job ended by timeout.
- `busy`  out  1  a job is in flight (state ≠ IDLE).
- `job_count`  out  16  completed jobs (finish or timeout), wraps.
- `timeout_count`  out  16  timed-out jobs, saturates at 0xFFFF.
- `stray_count`  out  8  `acc_finish` pulses outside WAIT, saturates at 0xFF.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE: `job_ready`=1 (forced 0 while `reset`=1). On `job_valid` → START.
- START: `acc_start`=1 for exactly this cycle; latency counter loads 1; → WAIT.
- WAIT: if `acc_finish` → DONE, capture `done_latency`=counter, `done_timeout`=0. Else if counter == `TIMEOUT_CYCLES` → DONE, `done_latency`=`TIMEOUT_CYCLES`, `done_timeout`=1. Else counter+1. Finish wins when both occur in the same cycle.
- DONE: `done_valid`=1 for this cycle; `job_count`+1; `timeout_count`+1 if timed out; → IDLE.
- `acc_finish` in IDLE, START or DONE: ignored for state, `stray_count`+1 (saturating). A late finish after timeout is therefore counted as stray, never attributed to the next job.
- `done_latency`/`done_timeout` hold their value until the next DONE.

## Timing
- Job accepted at cycle t → `acc_start` at t+1; finish at t+1+k → `done_valid` at t+2+k with `done_latency`=k; `job_ready` again at t+3+k.
- Minimum k=1 (finish the cycle after start); finish coincident with `acc_start` is stray.
- Timeout: no finish → `done_valid` at t+2+`TIMEOUT_CYCLES`.
- Throughput: one job per k+3 cycles; `job_ready`=0 in START/WAIT/DONE.
- All outputs registered or decoded from the state register; no input-to-output combinational path except `reset` gating of `job_ready`.
- Reset (any cycle, including mid-WAIT): state → IDLE; `acc_start`, `done_valid`, `done_timeout`, `busy` = 0; `done_latency`, all counters = 0. In-flight job is discarded without `done_valid`. `job_ready`=1 on the first cycle after `reset` deasserts.

## Structure
- Shared package `accel_ctrl_pkg`: state enum (IDLE, START, WAIT, DONE), default `TIMEOUT_CYCLES`, `LAT_W`, statistics counter widths.
- One natural sub-module: `sat_counter` (parameterised width, increment enable, synchronous clear, saturate flag), instanced for `timeout_count` and `stray_count`.

## Test plan
- Basic job: `job_valid` at t, model returns finish 5 cycles after `acc_start` → `acc_start` at t+1 only, `done_valid` at t+7, `done_latency`=5, `done_timeout`=0, `job_count`=1.
- Timeout: `TIMEOUT_CYCLES`=20, model never finishes → `done_valid` at t+22, `done_latency`=20, `done_timeout`=1, `timeout_count`=1; late finish at t+30 → `stray_count`=1.
- Boundary: finish exactly at counter=`TIMEOUT_CYCLES` → `done_timeout`=0, `done_latency`=20; finish coincident with `acc_start` → stray, job then times out.
- Back-to-back: `job_valid` held high, finish after 1 cycle each → 10 jobs in 40 cycles, `acc_start` every 4 cycles, `job_count`=10.
- Reset mid-WAIT: reset at 3rd WAIT cycle → no `done_valid`, all outputs/counters 0, `job_ready`=1 next cycle; new job completes normally.
- Saturation/wrap: 300 stray finishes in IDLE → `stray_count`=0xFF; 65537 jobs → `job_count`=1.
